// File: rtl/alu_exec_pkg.sv
// -----------------------------------------------------------------------------
// alu_exec_pkg
// Shared definitions for the ALU execute-stage slice:
//   alu_op_e   - 2-bit opcode (add, sub, and, xor)
//   CC_*_RST   - reset values of the ZF/SF/OF condition-code register
// -----------------------------------------------------------------------------
package alu_exec_pkg;

  typedef enum logic [1:0] {
    ALU_OP_ADD = 2'd0,
    ALU_OP_SUB = 2'd1,
    ALU_OP_AND = 2'd2,
    ALU_OP_XOR = 2'd3
  } alu_op_e;

  // After reset the flags describe a zero result.
  localparam logic CC_ZF_RST = 1'b1;
  localparam logic CC_SF_RST = 1'b0;
  localparam logic CC_OF_RST = 1'b0;

endpackage : alu_exec_pkg

// File: rtl/alu_exec_if.sv
// -----------------------------------------------------------------------------
// alu_exec_if
// Operand and result handshakes of the ALU execute unit.
//   in_valid/in_ready   operand beat handshake (in_a, in_b, in_op, in_set_cc)
//   out_valid/out_ready result beat handshake (out_result, out_cout, out_of)
// Modports:
//   master - initiator side (pipeline / stimulus), drives operands and out_ready
//   slave  - the execute unit
// -----------------------------------------------------------------------------
interface alu_exec_if
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 64
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  alu_op_e          in_op;
  logic             in_set_cc;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic             out_of;

  modport master (
    output in_valid, in_a, in_b, in_op, in_set_cc, out_ready,
    input  in_ready, out_valid, out_result, out_cout, out_of
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_set_cc, out_ready,
    output in_ready, out_valid, out_result, out_cout, out_of
  );

endinterface : alu_exec_if

// File: rtl/alu_exec_core.sv
// -----------------------------------------------------------------------------
// alu_exec_core
// Purely combinational ALU datapath.
//   a, b    operands (two's complement)
//   op      alu_op_e opcode
//   result  WIDTH-bit result
//   cout    carry out of the MSB (sub: 1 means no borrow); 0 for and/xor
//   of      signed overflow; 0 for and/xor
// -----------------------------------------------------------------------------
module alu_exec_core
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             of
);

  localparam int MSB = WIDTH - 1;

  logic             sub_sel;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   arith;

  // Subtraction shares the adder: A + ~B + 1.
  always_comb begin
    sub_sel = (op == ALU_OP_SUB);
    b_eff   = sub_sel ? ~b : b;
    arith   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    result = '0;
    cout   = 1'b0;
    of     = 1'b0;
    case (op)
      ALU_OP_ADD: begin
        result = arith[MSB:0];
        cout   = arith[WIDTH];
        of     = (a[MSB] == b[MSB]) && (arith[MSB] != a[MSB]);
      end
      ALU_OP_SUB: begin
        result = arith[MSB:0];
        cout   = arith[WIDTH];
        of     = (a[MSB] != b[MSB]) && (arith[MSB] != a[MSB]);
      end
      ALU_OP_AND: result = a & b;
      ALU_OP_XOR: result = a ^ b;
      default:    result = '0;
    endcase
  end

endmodule : alu_exec_core

// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
// Registered execute stage: accepts operand beats, computes them through
// alu_exec_core and returns result/carry/overflow one cycle later. Keeps a
// ZF/SF/OF condition-code register updated at acceptance when in_set_cc=1.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   bus            alu_exec_if.slave (operand and result handshakes)
//   cc_zf/sf/of    condition-code register
// Build option:
//   ALU_EXEC_SKID_EN  defined   -> 2-entry result FIFO, in_ready registered
//                     undefined -> single result register, in_ready depends
//                                  combinationally on out_ready
// -----------------------------------------------------------------------------
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  alu_exec_if.slave  bus,
  output logic       cc_zf,
  output logic       cc_sf,
  output logic       cc_of
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             of;
  } slot_t;

  slot_t core_out;
  slot_t out_slot;
  logic  accept;
  logic  emit;
  logic  out_valid;
  logic  in_ready;

  alu_exec_core #(.WIDTH(WIDTH)) u_core (
    .a      (bus.in_a),
    .b      (bus.in_b),
    .op     (bus.in_op),
    .result (core_out.result),
    .cout   (core_out.cout),
    .of     (core_out.of)
  );

  assign accept = bus.in_valid & in_ready;
  assign emit   = out_valid & bus.out_ready;

`ifdef ALU_EXEC_SKID_EN

  slot_t      fifo_mem [2];
  logic       head;
  logic       tail;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       in_ready_q;

  always_comb begin
    count_next = count;
    case ({accept, emit})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is cleared on reset because an empty FIFO still
      // presents fifo_mem[head] on out_*, which must read as zero.
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      head        <= 1'b0;
      tail        <= 1'b0;
      count       <= 2'd0;
      in_ready_q  <= 1'b1;
    end else begin
      if (accept) begin
        fifo_mem[tail] <= core_out;
        tail           <= ~tail;
      end
      if (emit) begin
        head <= ~head;
      end
      count      <= count_next;
      // Registered so there is no combinational path from out_ready.
      in_ready_q <= (count_next != 2'd2);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count != 2'd0);
  assign out_slot  = fifo_mem[head];

`else

  logic  out_valid_q;
  slot_t out_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      // Covers accept+emit too: the new beat replaces the departing one.
      out_valid_q <= 1'b1;
      out_q       <= core_out;
    end else if (emit) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready  = !out_valid_q || bus.out_ready;
  assign out_valid = out_valid_q;
  assign out_slot  = out_q;

`endif

  // Flags track accepted beats, independent of result backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc_zf <= CC_ZF_RST;
      cc_sf <= CC_SF_RST;
      cc_of <= CC_OF_RST;
    end else if (accept && bus.in_set_cc) begin
      cc_zf <= (core_out.result == '0);
      cc_sf <= core_out.result[WIDTH-1];
      cc_of <= core_out.of;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = out_slot.result;
  assign bus.out_cout   = out_slot.cout;
  assign bus.out_of     = out_slot.of;

endmodule : alu_exec_unit

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed vectors with hand-computed results. The driver pushes the expected
// result of each accepted beat into a queue; an independent monitor compares
// out_* against the queue head at every falling edge and pops on emit.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  typedef struct {
    logic [63:0] result;
    logic        cout;
    logic        of;
  } exp_t;

`ifdef ALU_EXEC_SKID_EN
  localparam int BP_DEPTH = 2;
`else
  localparam int BP_DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cc_zf, cc_sf, cc_of;

  int   checks   = 0;
  int   errors   = 0;
  int   accepted = 0;
  exp_t sb_q[$];

  alu_exec_if #(.WIDTH(64)) bus ();

  alu_exec_unit #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .cc_zf (cc_zf),
    .cc_sf (cc_sf),
    .cc_of (cc_of)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called aligned to posedge+#1; returns aligned to posedge+#1.
  task automatic send(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                      input logic set_cc, input logic [63:0] er, input logic ec,
                      input logic eo, input logic zf, input logic sf, input logic ofl);
    bit acc   = 1'b0;
    int waitc = 0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_op     = op;
    bus.in_set_cc = set_cc;
    while (!acc && waitc < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waitc++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat a=0x%0h not accepted within 50 cycles", a);
    end else begin
      accepted++;
      sb_q.push_back('{er, ec, eo});
      check("cc_zf", cc_zf, zf);
      check("cc_sf", cc_sf, sf);
      check("cc_of", cc_of, ofl);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: out_valid must match pending beats; out_* must match the head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("out_valid_vs_pending", bus.out_valid, sb_q.size() != 0);
        if (bus.out_valid && sb_q.size() != 0) begin
          e = sb_q[0];
          check("out_result", bus.out_result, e.result);
          check("out_cout", bus.out_cout, e.cout);
          check("out_of", bus.out_of, e.of);
          if (bus.out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = ALU_OP_ADD;
    bus.in_set_cc = 1'b0;
    bus.out_ready = 1'b1;

    // Reset for two cycles
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_result", bus.out_result, 64'd0);
    check("rst_out_cout", bus.out_cout, 1'b0);
    check("rst_out_of", bus.out_of, 1'b0);
    check("rst_cc_zf", cc_zf, 1'b1);
    check("rst_cc_sf", cc_sf, 1'b0);
    check("rst_cc_of", cc_of, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Arithmetic and logic vectors, back to back
    send(ALU_OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
         64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    send(ALU_OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
         64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send(ALU_OP_SUB, 64'd5, 64'd5, 1'b1,
         64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send(ALU_OP_SUB, 64'd3, 64'd5, 1'b1,
         64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(ALU_OP_AND, 64'hF0F0, 64'h0FF0, 1'b0,
         64'h00F0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(ALU_OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b1,
         64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send(ALU_OP_XOR, 64'hFF, 64'h0F, 1'b1,
         64'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    // Backpressure: out_ready low for 3 cycles while 4 beats stream in
    accepted      = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        send(ALU_OP_ADD, 64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(ALU_OP_SUB, 64'd10, 64'd3, 1'b0, 64'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send(ALU_OP_AND, 64'hFF, 64'h3C, 1'b0, 64'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(ALU_OP_XOR, 64'hAA, 64'h55, 1'b0, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready", bus.in_ready, 1'b0);
        check("bp_accepted", 64'(accepted), 64'(BP_DEPTH));
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_total_accepted", 64'(accepted), 64'd4);

    // Reset while a result is stalled
    bus.out_ready = 1'b0;
    send(ALU_OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
         64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", bus.out_valid, 1'b0);
    check("rst2_cc_zf", cc_zf, 1'b1);
    check("rst2_cc_sf", cc_sf, 1'b0);
    check("rst2_cc_of", cc_of, 1'b0);
    @(posedge clk);
    #1;
    send(ALU_OP_ADD, 64'h10, 64'h20, 1'b1, 64'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_alu_exec_unit
